// File: rtl/ht_pkg.sv
// Shared constants and FSM state type for the Huffman-tree decoder.
// Sized for up to 8 leaves, which gives 15 tree nodes with 4-bit ids.
package ht_pkg;

    localparam int NUM_LEAF_DEFAULT = 8;
    localparam int MAX_NODE         = 15;
    localparam int ID_W             = 4;
    localparam int W_W_DEFAULT      = 7;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUILD,
        DECODE
    } ht_state_e;

endpackage

// File: rtl/ht_min2.sv
// Combinational two-minimum search over live tree nodes.
// Ties always resolve to the lowest node id.
module ht_min2
    import ht_pkg::*;
#(
    parameter int N = MAX_NODE,
    parameter int W = W_W_DEFAULT
) (
    input  logic [N-1:0][W-1:0] weight,
    input  logic [N-1:0]        live,
    output logic [ID_W-1:0]     p0,
    output logic [ID_W-1:0]     p1
);

    logic         found0;
    logic         found1;
    logic [W-1:0] best0;
    logic [W-1:0] best1;

    always_comb begin
        p0     = '0;
        p1     = '0;
        found0 = 1'b0;
        found1 = 1'b0;
        best0  = '0;
        best1  = '0;
        // Strict '<' while scanning upward keeps the lowest id on ties.
        for (int i = 0; i < N; i++) begin
            if (live[i] && (!found0 || weight[i] < best0)) begin
                found0 = 1'b1;
                best0  = weight[i];
                p0     = ID_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (live[i] && (ID_W'(i) != p0) && (!found1 || weight[i] < best1)) begin
                found1 = 1'b1;
                best1  = weight[i];
                p1     = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/ht_decode.sv
// Huffman decoder: loads leaf weights, builds the tree one merge per cycle,
// then walks it one code bit per cycle. Optional macro HT_DEC_ERR_EN adds out_err.
module ht_decode
    import ht_pkg::*;
#(
    parameter int NUM_LEAF = NUM_LEAF_DEFAULT,
    parameter int W_W      = W_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_weight,
    output logic       code_ready,
    input  logic       code_valid,
    input  logic       code_bit,
    output logic       out_valid,
    output logic [2:0] out_char,
    output logic       out_err
);

    localparam logic [ID_W-1:0] ROOT_ID   = ID_W'(2 * NUM_LEAF - 2);
    localparam logic [ID_W-1:0] LAST_LEAF = ID_W'(NUM_LEAF - 1);
    localparam logic [ID_W-1:0] FIRST_INT = ID_W'(NUM_LEAF);

    ht_state_e                   state_q;
    ht_state_e                   state_d;
    logic [MAX_NODE-1:0][W_W-1:0] weight_q;
    logic [MAX_NODE-1:0]          live_q;
    logic [ID_W-1:0]              left_q  [MAX_NODE];
    logic [ID_W-1:0]              right_q [MAX_NODE];
    logic [ID_W-1:0]              load_cnt_q;
    logic [ID_W-1:0]              merge_id_q;
    logic [ID_W-1:0]              ptr_q;
    logic                         seen_bit_q;
    logic                         vld_p1;
    logic [2:0]                   char_p1;

    logic [ID_W-1:0] p0;
    logic [ID_W-1:0] p1;
    logic            p0_left;
    logic [ID_W-1:0] next_node;
    logic            hit_leaf;

    ht_min2 #(
        .N (MAX_NODE),
        .W (W_W)
    ) u_min2 (
        .weight (weight_q),
        .live   (live_q),
        .p0     (p0),
        .p1     (p1)
    );

    // The heavier child goes left; on equal weight the lower id goes left.
    assign p0_left = (weight_q[p0] > weight_q[p1]) ||
                     ((weight_q[p0] == weight_q[p1]) && (p0 < p1));

    assign next_node = code_bit ? right_q[ptr_q] : left_q[ptr_q];
    assign hit_leaf  = (next_node <= LAST_LEAF);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)                   state_d = LOAD;
            LOAD:    if (!in_valid)                  state_d = BUILD;
            BUILD:   if (merge_id_q == ROOT_ID)      state_d = DECODE;
            DECODE:  if (!code_valid && seen_bit_q)  state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= ROOT_ID;
            live_q     <= '0;
            weight_q   <= '0;
            load_cnt_q <= '0;
            merge_id_q <= FIRST_INT;
            seen_bit_q <= 1'b0;
            vld_p1     <= 1'b0;
            char_p1    <= '0;
        end else begin
            state_q <= state_d;
            vld_p1  <= 1'b0;
            char_p1 <= '0;
            case (state_q)
                IDLE: begin
                    ptr_q      <= ROOT_ID;
                    seen_bit_q <= 1'b0;
                    merge_id_q <= FIRST_INT;
                    // First weight arrives with the IDLE->LOAD strobe; wipe the old tree.
                    if (in_valid) begin
                        live_q      <= {{(MAX_NODE - 1){1'b0}}, 1'b1};
                        weight_q    <= '0;
                        weight_q[0] <= W_W'(in_weight);
                        load_cnt_q  <= ID_W'(1);
                    end
                end
                LOAD: begin
                    if (in_valid && (load_cnt_q <= LAST_LEAF)) begin
                        live_q[load_cnt_q]   <= 1'b1;
                        weight_q[load_cnt_q] <= W_W'(in_weight);
                        load_cnt_q           <= load_cnt_q + ID_W'(1);
                    end
                end
                BUILD: begin
                    live_q[p0]           <= 1'b0;
                    live_q[p1]           <= 1'b0;
                    live_q[merge_id_q]   <= 1'b1;
                    weight_q[merge_id_q] <= weight_q[p0] + weight_q[p1];
                    merge_id_q           <= merge_id_q + ID_W'(1);
                end
                DECODE: begin
                    if (code_valid) begin
                        seen_bit_q <= 1'b1;
                        if (hit_leaf) begin
                            vld_p1  <= 1'b1;
                            char_p1 <= next_node[2:0];
                            ptr_q   <= ROOT_ID;
                        end else begin
                            ptr_q <= next_node;
                        end
                    end else if (seen_bit_q) begin
                        ptr_q <= ROOT_ID;
                    end
                end
                default: ;
            endcase
        end
    end

    // Child links are pure data and only meaningful once BUILD has written them.
    always_ff @(posedge clk) begin
        if (state_q == BUILD) begin
            left_q[merge_id_q]  <= p0_left ? p0 : p1;
            right_q[merge_id_q] <= p0_left ? p1 : p0;
        end
    end

    assign code_ready = (state_q == DECODE);
    assign out_valid  = vld_p1;
    assign out_char   = char_p1;

`ifdef HT_DEC_ERR_EN
    logic err_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_p1 <= 1'b0;
        end else begin
            err_p1 <= (state_q == DECODE) && !code_valid && seen_bit_q && (ptr_q != ROOT_ID);
        end
    end

    assign out_err = err_p1;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_ht_decode.sv
// Self-checking bench for ht_decode: directed vectors plus random trees/messages
// checked against a code-table reference model.
module tb_ht_decode;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_weight = '0;
    logic       code_valid = 1'b0;
    logic       code_bit = 1'b0;
    logic       code_ready;
    logic       out_valid;
    logic [2:0] out_char;
    logic       out_err;

    int errors = 0;
    int checks = 0;

    int wts [8];
    int mw  [15];
    bit ml  [15];
    int par [15];
    int side[15];
    int code_val[8];
    int code_len[8];
    int acc = 0;
    int acc_len = 0;
    int got[$];
    int want[$];

    ht_decode dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_weight  (in_weight),
        .code_ready (code_ready),
        .code_valid (code_valid),
        .code_bit   (code_bit),
        .out_valid  (out_valid),
        .out_char   (out_char),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: build the tree by the min/tie rules, then derive each leaf's code word.
    function automatic void build_model();
        int a;
        int b;
        int nid;
        int n;
        for (int i = 0; i < 15; i++) begin
            ml[i] = 1'b0; mw[i] = 0; par[i] = -1; side[i] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            mw[i] = wts[i]; ml[i] = 1'b1;
        end
        for (int k = 0; k < 7; k++) begin
            a = -1;
            b = -1;
            for (int i = 0; i < 15; i++)
                if (ml[i] && (a < 0 || mw[i] < mw[a])) a = i;
            for (int i = 0; i < 15; i++)
                if (ml[i] && i != a && (b < 0 || mw[i] < mw[b])) b = i;
            nid = 8 + k;
            mw[nid] = mw[a] + mw[b];
            ml[a] = 1'b0; ml[b] = 1'b0; ml[nid] = 1'b1;
            par[a] = nid; par[b] = nid;
            if (mw[a] > mw[b] || (mw[a] == mw[b] && a < b)) begin
                side[a] = 0; side[b] = 1;
            end else begin
                side[b] = 0; side[a] = 1;
            end
        end
        for (int j = 0; j < 8; j++) begin
            code_val[j] = 0;
            code_len[j] = 0;
            n = j;
            while (n != 14 && n >= 0 && code_len[j] < 16) begin
                code_val[j] = code_val[j] | (side[n] << code_len[j]);
                code_len[j]++;
                n = par[n];
            end
        end
        acc = 0;
        acc_len = 0;
    endfunction

    task automatic load_tree();
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_weight = 3'(wts[i]);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        in_weight = '0;
        build_model();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (code_ready !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", code_ready, 1);
    endtask

    task automatic drive_bit(input logic b);
        int ev = 0;
        int ec = 0;
        code_valid = 1'b1;
        code_bit   = b;
        @(posedge clk); #1;
        acc = (acc << 1) | int'(b);
        acc_len++;
        for (int j = 0; j < 8; j++)
            if (code_len[j] == acc_len && code_val[j] == acc) begin
                ev = 1; ec = j;
            end
        if (ev == 1) begin
            acc = 0; acc_len = 0;
            got.push_back(ec);
        end
        chk("out_valid", out_valid, ev);
        chk("out_char", out_char, ec);
        chk("out_err_mid", out_err, 0);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) drive_bit(bits[i]);
    endtask

    task automatic end_msg();
        int ee;
`ifdef HT_DEC_ERR_EN
        ee = (acc_len != 0) ? 1 : 0;
`else
        ee = 0;
`endif
        code_valid = 1'b0;
        code_bit   = 1'b0;
        @(posedge clk); #1;
        chk("err_on_exit", out_err, ee);
        chk("ready_after_exit", code_ready, 0);
        chk("valid_after_exit", out_valid, 0);
        acc = 0;
        acc_len = 0;
        @(posedge clk); #1;
        chk("err_cleared", out_err, 0);
    endtask

    task automatic ignored_bits(input string tag);
        for (int i = 0; i < 3; i++) begin
            code_valid = 1'b1;
            code_bit   = 1'b0;
            @(posedge clk); #1;
            chk(tag, out_valid, 0);
        end
        code_valid = 1'b0;
    endtask

    task automatic check_got(input string tag);
        chk({tag, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++) chk(tag, got[i], want[i]);
    endtask

    initial begin
        int s;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_code_ready", code_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_char", out_char, 0);
        chk("rst_out_err", out_err, 0);
        rst = 1'b0;
        ignored_bits("idle_bit_ignored");

        // Equal weights; bits during BUILD must be ignored, ready after 7 merges.
        for (int i = 0; i < 8; i++) wts[i] = 1;
        load_tree();
        for (int n = 1; n <= 8; n++) begin
            code_valid = 1'b1;
            code_bit   = 1'($urandom);
            @(posedge clk); #1;
            chk("build_ready", code_ready, (n == 8) ? 1 : 0);
            chk("build_no_valid", out_valid, 0);
        end
        code_valid = 1'b0;
        got.delete();
        send_bits(32'b100101110111000, 15);
        want = '{4, 5, 6, 7, 0};
        check_got("equal_syms");
        end_msg();
        ignored_bits("idle_after_msg");

        // Skewed weights.
        wts = '{7, 1, 1, 1, 1, 1, 1, 1};
        load_tree();
        wait_ready();
        got.delete();
        send_bits(32'b01111100, 8);
        want = '{0, 7, 1};
        check_got("skew_syms");
        end_msg();

        // Partial code at exit.
        for (int i = 0; i < 8; i++) wts[i] = 1;
        load_tree();
        wait_ready();
        got.delete();
        send_bits(32'b10, 2);
        want.delete();
        check_got("partial_syms");
        end_msg();
        ignored_bits("idle_after_partial");

        // Reset mid-DECODE, then a fresh equal-weight tree.
        load_tree();
        wait_ready();
        send_bits(32'b1, 1);
        rst = 1'b1;
        code_valid = 1'b1;
        code_bit = 1'b1;
        @(posedge clk); #1;
        chk("rstdec_valid", out_valid, 0);
        chk("rstdec_char", out_char, 0);
        chk("rstdec_ready", code_ready, 0);
        chk("rstdec_err", out_err, 0);
        rst = 1'b0;
        code_valid = 1'b0;
        acc = 0;
        acc_len = 0;
        load_tree();
        wait_ready();
        got.delete();
        send_bits(32'b011, 3);
        want = '{3};
        check_got("after_rst_sym");
        end_msg();

        // Reset mid-BUILD.
        for (int i = 0; i < 8; i++) wts[i] = int'($urandom_range(0, 7));
        load_tree();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstbuild_ready", code_ready, 0);
        chk("rstbuild_valid", out_valid, 0);
        rst = 1'b0;

        // Random trees and messages.
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 8; i++) wts[i] = int'($urandom_range(0, 7));
            load_tree();
            wait_ready();
            got.delete();
            want.delete();
            for (int k = 0; k < 6; k++) begin
                s = int'($urandom_range(0, 7));
                want.push_back(s);
                for (int b = code_len[s] - 1; b >= 0; b--) drive_bit(1'((code_val[s] >> b) & 1));
            end
            check_got("rand_syms");
            end_msg();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ht_decode.md
HT_DECODE -- requirements
Module: ht_decode

Interface
REQ-001 SHALL have parameter NUM_LEAF, default 8, number of leaf symbols (indices 0..NUM_LEAF-1).
REQ-002 SHALL have parameter W_W, default 7, internal node-weight width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  weight-load strobe, NUM_LEAF consecutive cycles.
REQ-006 SHALL have port in_weight  input  3  leaf weight, leaf i on the i-th valid cycle.
REQ-007 SHALL have port code_ready  output  1  tree built, decoder accepts bits.
REQ-008 SHALL have port code_valid  input  1  serial code bit strobe.
REQ-009 SHALL have port code_bit  input  1  code bit, MSB-first; 0 = left, 1 = right.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse per decoded symbol.
REQ-011 SHALL have port out_char  output  3  decoded leaf index, valid with out_valid.
REQ-012 SHALL have port out_err  output  1  partial-code error pulse (HT_DEC_ERR_EN only).

Function
REQ-013 SHALL use FSM states IDLE, LOAD, BUILD, DECODE: IDLE->LOAD on in_valid; LOAD->BUILD when in_valid falls; BUILD->DECODE after NUM_LEAF-1 merges; DECODE->IDLE on code_valid fall after at least one accepted bit.
REQ-014 SHALL store weight i into node i in LOAD; in_valid outside IDLE/LOAD is ignored.
REQ-015 SHALL perform exactly one merge per BUILD cycle; new node ids NUM_LEAF..2*NUM_LEAF-2 in order; sum width W_W, no overflow for 3-bit leaves.
REQ-016 SHALL pick p0 = minimum-weight live node, ties to lowest id; p1 = next minimum under the same rule.
REQ-017 SHALL make p0 the left child when w[p0]>w[p1] or (equal and p0<p1); otherwise p1 is left.
REQ-018 SHALL assert code_ready only in DECODE; code_valid while code_ready=0 is ignored.
REQ-019 SHALL walk from root (node 2*NUM_LEAF-2) one edge per accepted bit; on reaching a leaf, pulse out_valid with out_char=leaf id on the next cycle and reset the walk to root in the same edge.
REQ-020 SHALL sustain one bit per cycle with no bubbles, including back-to-back symbols.
REQ-021 SHALL, on leaving DECODE, clear code_ready and discard any partial walk.
REQ-022 SHALL keep out_char at 0 whenever out_valid=0.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, force state IDLE, walk pointer to root, node valid flags and weights to 0; outputs code_ready, out_valid, out_char, out_err to 0.
REQ-024 SHALL treat rst asserted mid-LOAD, mid-BUILD or mid-DECODE identically: abort, no out_valid on the following cycle.

Configuration
REQ-025 SHALL, with macro HT_DEC_ERR_EN defined, pulse out_err for one cycle when DECODE exits with walk pointer not at root.
REQ-026 SHALL, without HT_DEC_ERR_EN, tie out_err to 0 and omit the detection logic; all other behaviour unchanged.

Structure
REQ-027 SHALL place NUM_LEAF default, MAX_NODE=15, ID_W=4, W_W default and the FSM state enum in shared package ht_pkg.
REQ-028 SHALL implement the two-minimum search over live nodes as combinational sub-module ht_min2 (weights/valids in, p0/p1 out).

Verification
REQ-029 SHALL cover: weights 1,1,1,1,1,1,1,1; bits 100 101 110 111 000 -> out_char 4,5,6,7,0, one pulse each, on the cycle after each third bit.
REQ-030 SHALL cover: weights 7,1,1,1,1,1,1,1; bits 0 111 1100 -> out_char 0,7,1.
REQ-031 SHALL cover: code_ready rises exactly 7 BUILD cycles after LOAD ends; bits sent while code_ready=0 -> no out_valid.
REQ-032 SHALL cover: equal weights, bits "10" then code_valid drops -> out_err=1 one cycle (HT_DEC_ERR_EN), 0 without macro; FSM back in IDLE.
REQ-033 SHALL cover: rst=1 mid-DECODE after bit "1" -> next cycle all outputs 0; reload equal weights and bits 011 -> out_char 3.
REQ-034 SHALL cover: second full message after IDLE with new weights decodes per new tree, no residue from the first.
